// File: rtl/sd_host_pkg.sv
// Shared state type and protocol constants for the SD host read engine.
package sd_host_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    WAIT_START,
    RX_DATA,
    RX_END,
    FINISH
  } host_state_t;

  localparam int         CMD_FRAME_BITS  = 48;
  localparam logic [5:0] CMD_READ_SINGLE = 6'd17;
  localparam logic [3:0] DAT_START       = 4'h0;
  localparam logic [3:0] DAT_END         = 4'hF;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7 + x^3 + 1, init 0) used to protect the command frame.
module sd_crc7 (
  input  logic       tb_clk,
  input  logic       tb_n_rst,
  input  logic       clear,
  input  logic       bit_in,
  input  logic       shift_en,
  output logic [6:0] crc
);

  logic fb;

  assign fb = crc[6] ^ bit_in;

  always_ff @(posedge tb_clk or negedge tb_n_rst) begin
    if (!tb_n_rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (shift_en) begin
      crc <= {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    end
  end

endmodule

// File: rtl/sd_host_read_ctrl.sv
// SD 4-bit host engine: sends one 48-bit command on CMD, then receives one data block on DAT.
// Define SD_CMD_CRC7_EN to fill the command CRC7 field; otherwise the field is sent as zero.
module sd_host_read_ctrl
  import sd_host_pkg::*;
#(
  parameter int BLOCK_BYTES    = 512,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        tb_clk,
  input  logic        tb_n_rst,
  input  logic        start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        cmd_out,
  output logic        cmd_oe,
  input  logic [3:0]  dat_in,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int NIB_W = $clog2(2 * BLOCK_BYTES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(2 * BLOCK_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]       BIT_TOP  = 6'(CMD_FRAME_BITS - 1);

  host_state_t      state, next_state;
  logic [39:0]      cmd_frame;
  logic [5:0]       bit_idx;
  logic [5:0]       next_idx;
  logic             next_bit;
  logic [NIB_W-1:0] nib_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [3:0]       hi_nib;
  logic [6:0]       crc;

`ifdef SD_CMD_CRC7_EN
  // The CRC absorbs each frame bit as it is loaded onto cmd_out, so it is final
  // before the first CRC bit is needed. Bit 47 is always 0 and leaves a zero CRC unchanged.
  sd_crc7 u_crc7 (
    .tb_clk   (tb_clk),
    .tb_n_rst (tb_n_rst),
    .clear    ((state == IDLE) && start),
    .bit_in   (next_bit),
    .shift_en ((state == SEND_CMD) && (bit_idx >= 6'd9)),
    .crc      (crc)
  );
`else
  assign crc = 7'b0000000;
`endif

  always_ff @(posedge tb_clk or negedge tb_n_rst) begin
    if (!tb_n_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (start) next_state = SEND_CMD;
      SEND_CMD:   if (bit_idx == 6'd0) next_state = WAIT_START;
      WAIT_START: begin
        if (dat_in == DAT_START) begin
          next_state = RX_DATA;
        end else if (to_cnt == TO_LAST) begin
          next_state = FINISH;
        end
      end
      RX_DATA:    if (nib_cnt == NIB_LAST) next_state = RX_END;
      RX_END:     next_state = FINISH;
      FINISH:     next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Frame bit that goes on cmd_out after the one currently being driven.
  always_comb begin
    next_idx = bit_idx - 6'd1;
    next_bit = 1'b1;
    if ((next_idx >= 6'd8) && (next_idx <= BIT_TOP)) begin
      next_bit = cmd_frame[next_idx - 6'd8];
    end else if ((next_idx >= 6'd1) && (next_idx <= 6'd7)) begin
      next_bit = crc[3'(next_idx - 6'd1)];
    end
  end

  always_ff @(posedge tb_clk or negedge tb_n_rst) begin
    if (!tb_n_rst) begin
      cmd_frame <= '0;
      bit_idx   <= '0;
      nib_cnt   <= '0;
      to_cnt    <= '0;
      hi_nib    <= '0;
      cmd_out   <= 1'b1;
      cmd_oe    <= 1'b0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      done     <= (next_state == FINISH);
      busy     <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            cmd_frame <= {1'b0, 1'b1, cmd_index, cmd_arg};
            error     <= 1'b0;
            bit_idx   <= BIT_TOP;
            cmd_out   <= 1'b0;
            cmd_oe    <= 1'b1;
          end
        end
        SEND_CMD: begin
          if (bit_idx == 6'd0) begin
            cmd_oe  <= 1'b0;
            cmd_out <= 1'b1;
            to_cnt  <= '0;
          end else begin
            bit_idx <= next_idx;
            cmd_out <= next_bit;
          end
        end
        WAIT_START: begin
          if (dat_in == DAT_START) begin
            nib_cnt <= '0;
          end else if (to_cnt == TO_LAST) begin
            error <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        RX_DATA: begin
          if (nib_cnt != NIB_LAST) begin
            nib_cnt <= nib_cnt + NIB_W'(1);
          end
          if (!nib_cnt[0]) begin
            hi_nib <= dat_in;
          end else begin
            rx_byte  <= {hi_nib, dat_in};
            rx_valid <= 1'b1;
          end
        end
        RX_END: begin
          if (dat_in != DAT_END) begin
            error <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_host_read_ctrl.sv
// Self-checking bench for sd_host_read_ctrl with a 3-byte block and a 16-cycle start-bit timeout.
module tb_sd_host_read_ctrl;
  import sd_host_pkg::*;

  localparam int BLOCK_BYTES    = 3;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int NIBS           = 2 * BLOCK_BYTES;

  logic        tb_clk    = 1'b0;
  logic        tb_n_rst  = 1'b0;
  logic        start     = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg   = '0;
  logic [3:0]  dat_in    = 4'hF;
  logic        cmd_out, cmd_oe, rx_valid, busy, done, error;
  logic [7:0]  rx_byte;

  int checks = 0;
  int errors = 0;

  logic [7:0] rx_q[$];
  int         done_cnt = 0;

  logic [3:0]  card_nibs [NIBS];
  logic [47:0] seen_frame;
  int          oe_cycles, wait_cycles, q_base, d_base, done_pulses;
  logic        oe_after, cmd_after, err_after_start, done_seen, err_at_done, busy_at_done, busy_after;

  always #5 tb_clk = ~tb_clk;

  sd_host_read_ctrl #(
    .BLOCK_BYTES    (BLOCK_BYTES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .tb_clk    (tb_clk),
    .tb_n_rst  (tb_n_rst),
    .start     (start),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .cmd_out   (cmd_out),
    .cmd_oe    (cmd_oe),
    .dat_in    (dat_in),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // Passive monitor of the byte stream and done pulses.
  always @(negedge tb_clk) begin
    if (rx_valid) rx_q.push_back(rx_byte);
    if (done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference CRC7: remainder of msg * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] crc7Ref(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'b1000_1001;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] modelFrame(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] body;
    logic [6:0]  c;
    body = {2'b01, idx, arg};
`ifdef SD_CMD_CRC7_EN
    c = crc7Ref(body);
`else
    c = 7'b0;
`endif
    return {body, c, 1'b1};
  endfunction

  // Issue one command and play the card side; records what the DUT did.
  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg, input int delay,
                               input logic [3:0] end_nib, input bit no_start, input bit mid_start);
    int k;
    q_base    = rx_q.size();
    d_base    = done_cnt;
    cmd_index = idx;
    cmd_arg   = arg;
    start     = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    err_after_start = error;
    seen_frame = '0;
    oe_cycles  = 0;
    for (int i = 47; i >= 0; i--) begin
      seen_frame[i] = cmd_out;
      if (cmd_oe) oe_cycles++;
      @(negedge tb_clk);
    end
    oe_after  = cmd_oe;
    cmd_after = cmd_out;
    k = 0;
    while (!done && k < 200) begin
      if (no_start || k < delay)           dat_in = 4'hF;
      else if (k == delay)                 dat_in = DAT_START;
      else if (k <= delay + NIBS)          dat_in = card_nibs[k - delay - 1];
      else if (k == delay + NIBS + 1)      dat_in = end_nib;
      else                                 dat_in = 4'hF;
      start = mid_start && (k == delay + 3);
      @(negedge tb_clk);
      k++;
    end
    wait_cycles  = k;
    dat_in       = 4'hF;
    done_seen    = done;
    err_at_done  = error;
    busy_at_done = busy;
    start = mid_start;
    @(negedge tb_clk);
    start = 1'b0;
    busy_after = busy;
    @(negedge tb_clk);
    done_pulses = done_cnt - d_base;
  endtask

  task automatic runCase(input string name, input logic [5:0] idx, input logic [31:0] arg, input int delay,
                         input logic [3:0] end_nib, input bit no_start, input bit mid_start,
                         input logic [47:0] exp_frame, input logic exp_err);
    int exp_count;
    $display("[TB] case %s", name);
    applyStimulus(idx, arg, delay, end_nib, no_start, mid_start);
    exp_count = no_start ? 0 : BLOCK_BYTES;
    checkOutput({name, ".frame"}, seen_frame, exp_frame);
    checkOutput({name, ".oe_cycles"}, oe_cycles, 48);
    checkOutput({name, ".oe_after"}, {oe_after, cmd_after}, 2'b01);
    checkOutput({name, ".err_clr"}, err_after_start, 1'b0);
    checkOutput({name, ".done_seen"}, done_seen, 1'b1);
    checkOutput({name, ".wait_cycles"}, wait_cycles, no_start ? TIMEOUT_CYCLES : delay + NIBS + 2);
    checkOutput({name, ".error"}, err_at_done, exp_err);
    checkOutput({name, ".busy_done"}, busy_at_done, 1'b1);
    checkOutput({name, ".busy_after"}, busy_after, 1'b0);
    checkOutput({name, ".done_pulses"}, done_pulses, 1);
    checkOutput({name, ".rx_count"}, rx_q.size() - q_base, exp_count);
    for (int i = 0; i < exp_count && q_base + i < rx_q.size(); i++) begin
      checkOutput({name, ".rx_byte"}, rx_q[q_base + i], card_nibs[2*i] * 16 + card_nibs[2*i + 1]);
    end
  endtask

  task automatic randomNibs();
    for (int i = 0; i < NIBS; i++) card_nibs[i] = 4'($urandom_range(0, 15));
  endtask

  initial begin
    logic [47:0] cmd17_frame;
    logic [5:0]  r_idx;
    logic [31:0] r_arg;
    int          d_rst;

    repeat (2) @(negedge tb_clk);
    checkOutput("rst.cmd_out", cmd_out, 1'b1);
    checkOutput("rst.cmd_oe", cmd_oe, 1'b0);
    checkOutput("rst.rx_byte", rx_byte, 8'h00);
    checkOutput("rst.rx_valid", rx_valid, 1'b0);
    checkOutput("rst.busy", busy, 1'b0);
    checkOutput("rst.done", done, 1'b0);
    checkOutput("rst.error", error, 1'b0);
    tb_n_rst = 1'b1;
    repeat (2) @(negedge tb_clk);

`ifdef SD_CMD_CRC7_EN
    cmd17_frame = 48'h51_0000_0000_55;
`else
    cmd17_frame = 48'h51_0000_0000_01;
`endif
    card_nibs = '{4'h4, 4'h2, 4'h4, 4'hD, 4'h3, 4'h6};
    runCase("cmd17", CMD_READ_SINGLE, 32'h0, 5, DAT_END, 1'b0, 1'b0, cmd17_frame, 1'b0);

    runCase("timeout", CMD_READ_SINGLE, 32'h0000_0200, 0, DAT_END, 1'b1, 1'b0,
            modelFrame(CMD_READ_SINGLE, 32'h0000_0200), 1'b1);

    randomNibs();
    r_arg = $urandom;
    runCase("bad_end", CMD_READ_SINGLE, r_arg, 3, 4'h7, 1'b0, 1'b0, modelFrame(CMD_READ_SINGLE, r_arg), 1'b1);

    for (int n = 0; n < 4; n++) begin
      randomNibs();
      r_idx = 6'($urandom_range(0, 63));
      r_arg = $urandom;
      runCase("random", r_idx, r_arg, int'($urandom_range(0, 12)), DAT_END, 1'b0, 1'b0,
              modelFrame(r_idx, r_arg), 1'b0);
    end

    $display("[TB] case reset_mid_cmd");
    cmd_index = CMD_READ_SINGLE;
    cmd_arg   = $urandom;
    start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    repeat (20) @(negedge tb_clk);
    checkOutput("pre_rst.cmd_oe", cmd_oe, 1'b1);
    d_rst = done_cnt;
    #2 tb_n_rst = 1'b0;
    #1;
    checkOutput("mid_rst.cmd_oe", cmd_oe, 1'b0);
    checkOutput("mid_rst.cmd_out", cmd_out, 1'b1);
    checkOutput("mid_rst.busy", busy, 1'b0);
    repeat (4) @(negedge tb_clk);
    checkOutput("mid_rst.no_done", done_cnt - d_rst, 0);
    tb_n_rst = 1'b1;
    repeat (2) @(negedge tb_clk);

    randomNibs();
    r_arg = $urandom;
    runCase("mid_start", CMD_READ_SINGLE, r_arg, 2, DAT_END, 1'b0, 1'b1, modelFrame(CMD_READ_SINGLE, r_arg), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
